// File: rtl/pulse_event_timestamper_pkg.sv
// Shared defaults and helpers for the pulse event timestamper.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package pulse_ts_pkg;

    localparam int TS_WIDTH_DEF    = 24;
    localparam int SEQ_WIDTH_DEF   = 8;
    localparam int DEPTH_DEF       = 16;
    localparam int ENTRY_WIDTH_DEF = SEQ_WIDTH_DEF + TS_WIDTH_DEF;

    // 8-bit increment that sticks at all-ones instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pulse_event_timestamper_if.sv
// Valid/ready stream carrying {seq, timestamp} event entries.
// Latency: n/a (wires only).
// Backpressure: producer holds ts_valid/ts_data while ts_ready is low.
interface pulse_ts_if
    import pulse_ts_pkg::*;
#(
    parameter int DATA_W = ENTRY_WIDTH_DEF
) ();

    logic              ts_valid;
    logic              ts_ready;
    logic [DATA_W-1:0] ts_data;

    modport master (output ts_valid, output ts_data, input ts_ready);
    modport slave  (input ts_valid, input ts_data, output ts_ready);

endinterface

// File: rtl/pulse_event_timestamper_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// Latency: write visible at head one cycle after the write edge.
// Backpressure: writes while full are discarded unless a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    // a full FIFO can still take a write when the head leaves in the same cycle
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

    // storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/pulse_event_timestamper.sv
// Timestamps rising edges of an asynchronous long pulse and queues {seq, ts} entries.
// Latency: event written 2 cycles after longsignal first sampled high; ts_valid one cycle later.
// Backpressure: FIFO absorbs DEPTH entries; further events are dropped and counted.
module pulse_event_timestamper
    import pulse_ts_pkg::*;
#(
    parameter int TS_WIDTH  = TS_WIDTH_DEF,
    parameter int SEQ_WIDTH = SEQ_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   longsignal,
    input  logic                   enable,
    pulse_ts_if.master             ts,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [7:0]             overflow_count
);

    localparam int EW = SEQ_WIDTH + TS_WIDTH;

    logic                 s1, s2, s3;
    logic                 det;
    logic                 pop;
    logic                 drop;
    logic                 full;
    logic                 empty;
    logic [TS_WIDTH-1:0]  ts_cnt;
    logic [SEQ_WIDTH-1:0] seq_cnt;
    logic [EW-1:0]        head;

    // synchronizer plus history flop; runs regardless of enable so a
    // re-enable in the middle of a high phase does not look like an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= longsignal;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign det  = s2 && !s3 && enable;
    assign pop  = !empty && ts.ts_ready;
    assign drop = det && full && !pop;

    // free-running timestamp, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) ts_cnt <= '0;
        else       ts_cnt <= ts_cnt + TS_WIDTH'(1);
    end

    // sequence number advances on every event, dropped ones included,
    // so a consumer can see gaps
    always_ff @(posedge clk) begin
        if (reset)    seq_cnt <= '0;
        else if (det) seq_cnt <= seq_cnt + SEQ_WIDTH'(1);
    end

    // saturating count of events lost to a full FIFO
    always_ff @(posedge clk) begin
        if (reset)     overflow_count <= '0;
        else if (drop) overflow_count <= sat_inc8(overflow_count);
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (det),
        .wr_data ({seq_cnt, ts_cnt}),
        .full    (full),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (empty),
        .count   (fifo_count)
    );

    assign ts.ts_valid = !empty;
    assign ts.ts_data  = empty ? '0 : head;

endmodule

// File: tb/tb_pulse_event_timestamper.sv
// Scoreboard bench for pulse_event_timestamper: expected entries queued at stimulus, checked on pop.
// Latency: n/a.
// Backpressure: bench drives ts_ready per scenario.
module tb_pulse_event_timestamper;

    logic        clk = 1'b0;
    logic        reset;
    logic        longsignal;
    logic        enable;
    logic [4:0]  fifo_count;
    logic [7:0]  overflow_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    logic [7:0]  seq_m;
    logic [31:0] cyc = 0;
    logic [31:0] base = 0;

    pulse_ts_if #(.DATA_W(32)) ts_bus ();

    pulse_event_timestamper dut (
        .clk            (clk),
        .reset          (reset),
        .longsignal     (longsignal),
        .enable         (enable),
        .ts             (ts_bus),
        .fifo_count     (fifo_count),
        .overflow_count (overflow_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // timestamp the DUT should hold in the current cycle
    function automatic logic [23:0] exp_ts();
        return 24'(cyc - base);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        longsignal = 1'b0;
        enable = 1'b1;
        ts_bus.ts_ready = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        base = cyc;
        sb.delete();
        seq_m = 8'd0;
    endtask

    task automatic pulse(input int hi, input int lo, input bit store);
        if (store) sb.push_back({seq_m, exp_ts() + 24'd2});
        seq_m++;
        longsignal = 1'b1;
        repeat (hi) step();
        longsignal = 1'b0;
        repeat (lo) step();
    endtask

    task automatic drain();
        bit done = 1'b0;
        ts_bus.ts_ready = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            if (sb.size() == 0 && fifo_count == 5'd0) done = 1'b1;
        end
        ts_bus.ts_ready = 1'b0;
        check("drain_done", {31'd0, done}, 32'd1);
    endtask

    // scoreboard pop on accepted handshakes; idle data must be zero
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (ts_bus.ts_valid && ts_bus.ts_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_pop", ts_bus.ts_data, 32'hDEAD_BEEF);
                end else begin
                    check("entry", ts_bus.ts_data, sb.pop_front());
                end
            end
        end
        if (ts_bus.ts_valid === 1'b0) check("idle_data_zero", ts_bus.ts_data, 32'd0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        longsignal = 1'b0;
        enable = 1'b1;
        ts_bus.ts_ready = 1'b0;
        seq_m = 8'd0;

        // basic latency: high at cycle 10 -> ts 12, valid at 13
        do_reset();
        check("rst_valid", {31'd0, ts_bus.ts_valid}, 32'd0);
        check("rst_count", {27'd0, fifo_count}, 32'd0);
        check("rst_ovf", {24'd0, overflow_count}, 32'd0);
        repeat (10) step();
        sb.push_back({8'd0, 24'd12});
        seq_m++;
        longsignal = 1'b1;
        step();
        check("valid_c11", {31'd0, ts_bus.ts_valid}, 32'd0);
        step();
        check("valid_c12", {31'd0, ts_bus.ts_valid}, 32'd0);
        step();
        check("valid_c13", {31'd0, ts_bus.ts_valid}, 32'd1);
        check("count_c13", {27'd0, fifo_count}, 32'd1);
        step();
        longsignal = 1'b0;
        repeat (3) step();
        drain();

        // 17 events with no consumer: one drop, then a seq gap
        do_reset();
        for (int i = 0; i < 17; i++) pulse(3, 3, i < 16);
        repeat (3) step();
        check("full_count", {27'd0, fifo_count}, 32'd16);
        check("ovf_one", {24'd0, overflow_count}, 32'd1);
        drain();
        pulse(3, 3, 1'b1);
        drain();

        // saturation of overflow_count, then seq wrap after drain
        do_reset();
        for (int i = 0; i < 16; i++) pulse(2, 2, 1'b1);
        for (int i = 0; i < 300; i++) begin
            pulse(2, 2, 1'b0);
            if (i == 254) check("ovf_255", {24'd0, overflow_count}, 32'd255);
        end
        step();
        check("ovf_sat", {24'd0, overflow_count}, 32'd255);
        check("sat_count", {27'd0, fifo_count}, 32'd16);
        drain();
        pulse(2, 2, 1'b1);
        drain();

        // event coinciding with a pop while full is accepted
        do_reset();
        for (int i = 0; i < 16; i++) pulse(2, 2, 1'b1);
        check("fill_count", {27'd0, fifo_count}, 32'd16);
        sb.push_back({seq_m, exp_ts() + 24'd2});
        seq_m++;
        longsignal = 1'b1;
        step();
        step();
        ts_bus.ts_ready = 1'b1;
        step();
        ts_bus.ts_ready = 1'b0;
        check("coinc_count", {27'd0, fifo_count}, 32'd16);
        check("coinc_ovf", {24'd0, overflow_count}, 32'd0);
        step();
        longsignal = 1'b0;
        repeat (2) step();
        drain();

        // re-enable during a high phase makes no event
        do_reset();
        enable = 1'b0;
        longsignal = 1'b1;
        repeat (4) step();
        enable = 1'b1;
        repeat (2) step();
        longsignal = 1'b0;
        repeat (3) step();
        check("reen_count", {27'd0, fifo_count}, 32'd0);
        check("reen_valid", {31'd0, ts_bus.ts_valid}, 32'd0);
        pulse(3, 3, 1'b1);
        drain();

        // timestamp wrap, then reset with entries stored
        do_reset();
        repeat (5) step();
        sb.push_back({seq_m, 24'hFFFFFF});
        seq_m++;
        longsignal = 1'b1;
        step();
        force dut.ts_cnt = 24'hFFFFFE;
        base = cyc - 32'h00FF_FFFE;
        #1;
        release dut.ts_cnt;
        repeat (3) step();
        longsignal = 1'b0;
        repeat (2) step();
        check("wrap_ts_now", {8'd0, exp_ts()}, 32'd3);
        pulse(4, 3, 1'b1);
        drain();
        for (int i = 0; i < 3; i++) pulse(2, 2, 1'b1);
        check("pre_rst_count", {27'd0, fifo_count}, 32'd3);
        reset = 1'b1;
        step();
        sb.delete();
        check("mid_rst_valid", {31'd0, ts_bus.ts_valid}, 32'd0);
        check("mid_rst_count", {27'd0, fifo_count}, 32'd0);
        check("mid_rst_data", ts_bus.ts_data, 32'd0);
        reset = 1'b0;
        step();
        check("final_sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_event_timestamper.md
PULSE_EVENT_TIMESTAMPER -- requirements
Module: pulse_event_timestamper

Interface
REQ-001 SHALL have parameter TS_WIDTH, default 24: width of the free-running timestamp.
REQ-002 SHALL have parameter SEQ_WIDTH, default 8: width of the event sequence number.
REQ-003 SHALL have parameter DEPTH, default 16: number of event FIFO entries; power of two.
REQ-004 SHALL have port clk  input  1  the single slow clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port longsignal  input  1  prolonged pulse from the fast domain, asynchronous to clk.
REQ-007 SHALL have port enable  input  1  event capture enable.
REQ-008 SHALL have port ts_ready  input  1  consumer accepts the head entry.
REQ-009 SHALL have port ts_valid  output  1  FIFO head entry available.
REQ-010 SHALL have port ts_data  output  SEQ_WIDTH+TS_WIDTH  {seq, timestamp} of the head entry.
REQ-011 SHALL have port fifo_count  output  log2(DEPTH)+1  number of stored entries.
REQ-012 SHALL have port overflow_count  output  8  count of events dropped because the FIFO was full; saturates.

Function
REQ-013 SHALL pass longsignal through a 2-flop synchronizer (s1, s2), followed by a history flop s3.
REQ-014 SHALL detect an event in any cycle where s2=1, s3=0 and enable=1.
REQ-015 SHALL detect the event 2 cycles after the first rising clk edge that samples longsignal high.
REQ-016 SHALL require longsignal high and low phases of at least 2 clk cycles each; shorter pulses may be lost, with no error flag.
REQ-017 SHALL run a TS_WIDTH timestamp counter that increments every cycle, regardless of enable, and wraps from all-ones to 0.
REQ-018 SHALL store the timestamp value of the event-detection cycle.
REQ-019 SHALL increment the SEQ_WIDTH sequence counter, with wrap-around, on every detected event, including dropped events, so consumers see gaps.
REQ-020 SHALL store the pre-increment sequence value with each event, so the first event after reset carries seq 0.
REQ-021 SHALL write {seq, timestamp} into the FIFO in the event-detection cycle.
REQ-022 SHALL assert ts_valid starting the cycle after that write when the FIFO was previously empty.
REQ-023 SHALL pop the head entry on a rising clk edge where ts_valid=1 and ts_ready=1.
REQ-024 SHALL keep the head entry and ts_valid stable while ts_valid=1 and ts_ready=0.
REQ-025 SHALL drive ts_data to 0 whenever ts_valid=0.
REQ-026 SHALL accept an event arriving while the FIFO is full if a pop occurs in the same cycle; fifo_count stays DEPTH.
REQ-027 SHALL drop an event arriving while the FIFO is full with no pop, and increment overflow_count, saturating at 255.
REQ-028 SHALL treat a simultaneous write and pop on a non-empty, non-full FIFO as leaving fifo_count unchanged.
REQ-029 SHALL treat a simultaneous write and pop on an empty FIFO as impossible: ts_valid=0 means no pop occurs.
REQ-030 SHALL ignore ts_ready while ts_valid=0.
REQ-031 SHALL keep the synchronizer and history flop running while enable=0, so re-enabling during a high phase creates no event.
REQ-032 SHALL leave FIFO readout functional while enable=0.

Reset
REQ-033 SHALL clear s1, s2, s3, the timestamp, seq, FIFO pointers, fifo_count and overflow_count to 0 on reset.
REQ-034 SHALL drive ts_valid=0 and ts_data=0 in the cycle after reset is sampled high and while reset stays high.
REQ-035 SHALL discard all stored entries on reset mid-operation.
REQ-036 SHALL record no event in a reset cycle; the first possible event is 3 cycles after reset deasserts with longsignal already high.

Structure
REQ-037 SHALL place TS_WIDTH, SEQ_WIDTH and DEPTH defaults and the entry-width constant in shared package pulse_ts_pkg.
REQ-038 SHALL implement the FIFO as sub-module sync_fifo (parameterised width/depth, wr_en/full, rd_en/empty, count).
REQ-039 SHALL keep the synchronizer, edge detection, timestamp, seq and overflow logic in the top module.

Verification
REQ-040 SHALL verify: reset, then longsignal high at cycle 10 for 4 cycles -> one entry, seq 0, timestamp 12; ts_valid=1 at cycle 13.
REQ-041 SHALL verify: ts_ready=0, 17 pulses spaced 6 cycles -> fifo_count=16, overflow_count=1; drain shows seq 0..15, then a gap.
REQ-042 SHALL verify: 300 events with FIFO full and ts_ready=0 -> overflow_count saturates at 255 and stays there.
REQ-043 SHALL verify: FIFO full, event coincides with a pop -> accepted, fifo_count=16, overflow_count unchanged.
REQ-044 SHALL verify: enable=0 during a pulse, then enable=1 while longsignal is still high -> no entry; the next pulse is recorded with seq 0.
REQ-045 SHALL verify: timestamp preset near wrap (force 0xFFFFFE), event -> stored timestamps 0xFFFFFF then 0x000005 across the wrap; reset with 3 entries stored -> ts_valid=0, fifo_count=0 the next cycle.
